// File: rtl/alu_pipe_param.sv
// alu_pipe_param: WIDTH-bit ALU with a LATENCY-deep result pipeline.
// It uses a valid/ready handshake. The whole pipeline stalls on output
// backpressure. A persistent carry flag lets ADC/SBB chain multi-word arithmetic.
// The result and flags are computed when an op is accepted. They then ride
// through the stage registers together with a valid bit.
module alu_pipe_param #(
  parameter int WIDTH      = 8,
  parameter int LATENCY    = 8,
  parameter bit SIGNED_CMP = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic             carry_out,
  output logic             equal,
  output logic             greater,
  output logic             smaller,
  output logic             zero
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SUB  = 4'b0001,
    OP_RSV0 = 4'b0010,
    OP_NEG0 = 4'b0011,
    OP_ADC  = 4'b0100,
    OP_SBB  = 4'b0101,
    OP_RSV1 = 4'b0110,
    OP_NEG1 = 4'b0111,
    OP_AND  = 4'b1000,
    OP_XOR  = 4'b1001,
    OP_OR   = 4'b1010,
    OP_NOT  = 4'b1011,
    OP_SHR  = 4'b1100,
    OP_SHL  = 4'b1101,
    OP_ROR  = 4'b1110,
    OP_ROL  = 4'b1111
  } op_e;

  // One pipeline slot. Bubbles carry an all-zero payload, so the flags read 0
  // whenever the output is not valid.
  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] res;
    logic             carry;
    logic             eq;
    logic             gt;
    logic             lt;
    logic             zero;
  } stage_t;

  stage_t           r_stage [LATENCY];
  logic             r_cf;

  stage_t           w_new;
  logic             w_adv;
  logic             w_accept;
  logic             w_cin;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_res;
  logic             w_carry;
  logic             w_cf_upd;
  logic             w_eq;
  logic             w_lt;
  logic             w_gt;

  // The pipeline only moves when the output slot is empty or being drained.
  // Stage 0 is loaded on the same edge, so a full pipe keeps streaming at
  // one op per cycle.
  assign in_ready = !(out_valid && !out_ready);
  assign w_adv    = in_ready;
  assign w_accept = in_valid && in_ready;

  // Only ADC/SBB consume the stored carry. The other ops see a zero carry-in.
  assign w_cin  = (alu_sel == OP_ADC) || (alu_sel == OP_SBB) ? r_cf : 1'b0;
  assign w_sum  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, w_cin};
  // Top bit of the (WIDTH+1)-bit difference is set exactly when it went negative.
  assign w_diff = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, w_cin};

  generate
    if (SIGNED_CMP) begin : g_cmp_signed
      assign w_lt = $signed(a) < $signed(b);
    end else begin : g_cmp_unsigned
      assign w_lt = a < b;
    end
  endgenerate
  assign w_eq = (a == b);
  assign w_gt = !w_eq && !w_lt;

  // Opcode decode: result, carry/borrow/shift-out, and whether cf is written.
  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    w_res    = '0;
    w_carry  = 1'b0;
    w_cf_upd = 1'b0;
    case (op_e'(alu_sel))
      OP_ADD, OP_ADC: begin
        w_res    = w_sum[WIDTH-1:0];
        w_carry  = w_sum[WIDTH];
        w_cf_upd = 1'b1;
      end
      OP_SUB, OP_SBB: begin
        w_res    = w_diff[WIDTH-1:0];
        w_carry  = w_diff[WIDTH];
        w_cf_upd = 1'b1;
      end
      OP_NEG0, OP_NEG1: w_res = (~b) + WIDTH'(1);
      OP_AND:           w_res = a & b;
      OP_XOR:           w_res = a ^ b;
      OP_OR:            w_res = a | b;
      OP_NOT:           w_res = ~b;
      OP_SHR: begin
        w_res   = {1'b0, a[WIDTH-1:1]};
        w_carry = a[0];
      end
      OP_SHL: begin
        w_res   = {a[WIDTH-2:0], 1'b0};
        w_carry = a[WIDTH-1];
      end
      OP_ROR: begin
        w_res   = {a[0], a[WIDTH-1:1]};
        w_carry = a[0];
      end
      OP_ROL: begin
        w_res   = {a[WIDTH-2:0], a[WIDTH-1]};
        w_carry = a[WIDTH-1];
      end
      default: ; // reserved opcodes: result 0, carry 0, cf untouched
    endcase
  end

  // Build the slot entering stage 0. A bubble enters as all zeros.
  always_comb begin
    w_new = '0;
    if (in_valid) begin
      w_new.valid = 1'b1;
      w_new.res   = w_res;
      w_new.carry = w_carry;
      w_new.eq    = w_eq;
      w_new.gt    = w_gt;
      w_new.lt    = w_lt;
      w_new.zero  = (w_res == '0);
    end
  end

  // Advance the pipeline and update the carry flag on accept. A reset flushes everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the stage array is reset because every slot's valid bit and flags must read 0 after reset.
      for (int i = 0; i < LATENCY; i++) r_stage[i] <= '0;
      r_cf <= 1'b0;
    end else if (w_adv) begin
      // NOTE: non-blocking assignments let each stage capture its neighbour's old value.
      r_stage[0] <= w_new;
      for (int i = 1; i < LATENCY; i++) r_stage[i] <= r_stage[i-1];
      if (w_accept && w_cf_upd) r_cf <= w_carry;
    end
  end

  assign out_valid = r_stage[LATENCY-1].valid;
  assign alu_out   = r_stage[LATENCY-1].res;
  assign carry_out = r_stage[LATENCY-1].carry;
  assign equal     = r_stage[LATENCY-1].eq;
  assign greater   = r_stage[LATENCY-1].gt;
  assign smaller   = r_stage[LATENCY-1].lt;
  assign zero      = r_stage[LATENCY-1].zero;

endmodule

// File: tb/tb_alu_pipe_param.sv
// Directed bench for alu_pipe_param (WIDTH=8, LATENCY=8).
// Two instances share all inputs: one uses an unsigned compare and one a signed compare.
// Expected results are hand-computed and queued at accept.
// They are compared whenever the output is valid, and popped when the output is consumed.
module tb_alu_pipe_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       out_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic [3:0] sel;

  logic       u_in_ready, u_out_valid, u_carry, u_eq, u_gt, u_lt, u_zero;
  logic [7:0] u_alu_out;
  logic       s_in_ready, s_out_valid, s_carry, s_eq, s_gt, s_lt, s_zero;
  logic [7:0] s_alu_out;

  typedef struct {
    logic [7:0] res;
    logic       c;
    logic [2:0] fu;  // {equal, greater, smaller} with unsigned compare
    logic [2:0] fs;  // {equal, greater, smaller} with signed compare
    logic       z;
  } exp_t;

  exp_t q[$];
  exp_t none;
  int   n_pass  = 0;
  int   n_fail  = 0;
  int   n_total = 0;

  alu_pipe_param #(.WIDTH(8), .LATENCY(8), .SIGNED_CMP(1'b0)) dut_u (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(u_in_ready),
    .a(a), .b(b), .alu_sel(sel), .out_valid(u_out_valid), .out_ready(out_ready),
    .alu_out(u_alu_out), .carry_out(u_carry), .equal(u_eq), .greater(u_gt),
    .smaller(u_lt), .zero(u_zero)
  );

  alu_pipe_param #(.WIDTH(8), .LATENCY(8), .SIGNED_CMP(1'b1)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
    .a(a), .b(b), .alu_sel(sel), .out_valid(s_out_valid), .out_ready(out_ready),
    .alu_out(s_alu_out), .carry_out(s_carry), .equal(s_eq), .greater(s_gt),
    .smaller(s_lt), .zero(s_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "simulation timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] r, input logic c,
                              input logic [2:0] fu, input logic [2:0] fs);
    exp_t e;
    e.res = r;
    e.c   = c;
    e.fu  = fu;
    e.fs  = fs;
    e.z   = (r == 8'h00);
    return e;
  endfunction

  // One clock. It checks the outputs seen this cycle and records the handshakes
  // that the next edge will perform. Then it advances to the following negedge.
  task automatic tick(input exp_t e);
    exp_t f;
    #1;
    if (u_out_valid) begin
      if (q.size() == 0) begin
        check("spurious_out", {31'd0, u_out_valid}, 32'd0);
      end else begin
        f = q[0];
        check("out_u", {19'd0, u_alu_out, u_carry, u_eq, u_gt, u_lt, u_zero},
                       {19'd0, f.res, f.c, f.fu, f.z});
        check("out_s", {20'd0, s_out_valid, s_eq, s_gt, s_lt, s_alu_out},
                       {20'd0, 1'b1, f.fs, f.res});
        if (out_ready) void'(q.pop_front());
      end
    end else begin
      check("idle_flags", {24'd0, s_out_valid, u_eq, u_gt, u_lt, s_eq, s_gt, s_lt, u_zero}, 32'd0);
    end
    if (in_valid && u_in_ready && !rst) q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] a_i, input logic [7:0] b_i,
                      input logic [3:0] s_i, input exp_t e);
    a = a_i;
    b = b_i;
    sel = s_i;
    in_valid = 1'b1;
    tick(e);
    in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    in_valid = 1'b0;
    while (q.size() > 0 && n < 40) begin
      tick(none);
      n++;
    end
    check(tag, q.size(), 0);
  endtask

  logic [7:0] sweep_res [16];
  logic [7:0] shf_res   [4];

  initial begin
    int n;
    int sent;
    int hold;
    logic acc;

    sweep_res = '{8'h18, 8'h10, 8'h00, 8'hFC, 8'h18, 8'h10, 8'h00, 8'hFC,
                  8'h04, 8'h10, 8'h14, 8'hFB, 8'h0A, 8'h28, 8'h0A, 8'h28};
    shf_res   = '{8'h40, 8'h02, 8'hC0, 8'h03};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; sel = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_outputs", {24'd0, u_out_valid, u_carry, u_eq, u_gt, u_lt, u_zero, 2'b00}, 32'd0);
    check("rst_data", {24'd0, u_alu_out}, 32'd0);
    rst = 1'b0;
    out_ready = 1'b0;
    #1;
    check("rst_in_ready", {31'd0, u_in_ready}, 32'd1);
    out_ready = 1'b1;
    @(negedge clk);

    // Basic add and its latency. The accepting edge is k. The result must be
    // visible after edge k+7, which is 7 further edges.
    send(8'h14, 8'h04, 4'b0000, mk(8'h18, 1'b0, 3'b010, 3'b010));
    n = 0;
    while (!u_out_valid && n < 20) begin
      tick(none);
      n++;
    end
    check("latency", n, 7);
    drain("basic_drain");

    // Full opcode sweep, one op per cycle.
    for (int i = 0; i < 16; i++) begin
      a = 8'h14; b = 8'h04; sel = 4'(i); in_valid = 1'b1;
      tick(mk(sweep_res[i], 1'b0, 3'b010, 3'b010));
    end
    drain("sweep_drain");

    // Shift-out carries with both edge bits set. 0x81 is negative when signed.
    for (int i = 0; i < 4; i++) begin
      a = 8'h81; b = 8'h00; sel = 4'(12 + i); in_valid = 1'b1;
      tick(mk(shf_res[i], 1'b1, 3'b010, 3'b001));
    end
    drain("shift_drain");

    // Carry chain, back to back.
    a = 8'hFF; b = 8'h01; sel = 4'b0000; in_valid = 1'b1;
    tick(mk(8'h00, 1'b1, 3'b010, 3'b001));
    a = 8'h00; b = 8'h00; sel = 4'b0100;
    tick(mk(8'h01, 1'b0, 3'b100, 3'b100));
    a = 8'h00; b = 8'h01; sel = 4'b0001;
    tick(mk(8'hFF, 1'b1, 3'b001, 3'b001));
    a = 8'h05; b = 8'h01; sel = 4'b0101;
    tick(mk(8'h03, 1'b0, 3'b010, 3'b010));
    drain("chain_drain");

    // Signed versus unsigned compare on the same operands.
    send(8'h0A, 8'hF6, 4'b0000, mk(8'h00, 1'b1, 3'b001, 3'b010));
    drain("cmp_drain");

    // Backpressure. Stream 12 adds and hold out_ready low for 5 cycles
    // once the first result shows.
    sent = 0;
    hold = 0;
    for (int cyc = 0; cyc < 80 && (sent < 12 || q.size() > 0); cyc++) begin
      in_valid = (sent < 12);
      a = 8'h10 + 8'(sent); b = 8'h01; sel = 4'b0000;
      if (u_out_valid && hold < 5) begin
        out_ready = 1'b0;
        hold++;
      end else begin
        out_ready = 1'b1;
      end
      #1;
      if (!out_ready) check("bp_in_ready", {31'd0, u_in_ready}, 32'd0);
      acc = in_valid && u_in_ready;
      tick(mk(8'h11 + 8'(sent), 1'b0, 3'b010, 3'b010));
      if (acc) sent++;
    end
    out_ready = 1'b1;
    in_valid = 1'b0;
    check("bp_sent", sent, 12);
    check("bp_hold", hold, 5);
    check("bp_drain", q.size(), 0);

    // Reset with four ops in flight. These ops also leave cf=1 beforehand.
    for (int i = 0; i < 4; i++) begin
      a = 8'hFF; b = 8'h01; sel = 4'b0000; in_valid = 1'b1;
      tick(mk(8'h00, 1'b1, 3'b010, 3'b001));
    end
    in_valid = 1'b0;
    rst = 1'b1;
    tick(none);
    check("rst_mid_outputs", {16'd0, u_out_valid, u_alu_out, u_carry, u_eq, u_gt, u_lt, u_zero, 2'b00}, 32'd0);
    q.delete();
    rst = 1'b0;
    for (int i = 0; i < 12; i++) tick(none);
    send(8'h01, 8'h01, 4'b0100, mk(8'h02, 1'b0, 3'b100, 3'b100));
    drain("post_rst_drain");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_pipe_param.md
Name: alu_pipe_param

Overview:
- Parametrised successor to the team's fixed 8-bit registered ALU.
- WIDTH-bit operands, configurable pipeline depth, valid/ready handshake with backpressure, and a persistent carry flag for multi-word add/subtract chaining (ADC/SBB).
- Keeps the 4-bit opcode map and the equal/greater/smaller flags; sits between the operand register file and writeback.

Parameters:
- WIDTH, 8, operand/result width in bits (min 2).
- LATENCY, 8, pipeline stages from accept to output (min 1).
- SIGNED_CMP, 0, 1 = equal/greater/smaller use two's-complement compare; 0 = unsigned.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operation presented.
- in_ready  out  1  block can accept this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- alu_sel  in  4  opcode.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- alu_out  out  WIDTH  result.
- carry_out  out  1  carry/borrow/shift-out of this result.
- equal, greater, smaller  out  1 each  A vs B compare for this op.
- zero  out  1  alu_out == 0.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset: all stage valid bits, out_valid, carry flag, alu_out, carry_out, flags and zero clear to 0. in_ready is 1 in the first cycle after reset.
- Reset mid-operation: discards every in-flight op, with no output for them.
- Accept: on an edge with in_valid && in_ready.
- in_ready = !(out_valid && !out_ready). When 0, the whole pipeline holds, all stages frozen and the output stable.
- Result computation: at the accept stage, then shifted through LATENCY-1 register stages. Each stage carries a valid bit; bubbles propagate as valid=0.
- Latency: op accepted at edge k gives out_valid=1 after edge k+LATENCY-1, i.e. the result is visible in the cycle following that edge, with no stalls. Throughput is 1 op/cycle.
- Output hold: out_valid holds with stable data until out_ready is 1.
- Carry flag (internal cf): updated only at accept of opcodes 0000, 0001, 0100, 0101, with the carry/borrow produced. All other opcodes leave cf unchanged. Back-to-back ADC uses the cf of the immediately preceding accepted op.
- Opcode map (results truncated to WIDTH):
  - 0000 ADD: A+B; carry_out = bit WIDTH.
  - 0001 SUB: A-B; carry_out = borrow (1 iff A<B unsigned).
  - 0100 ADC: A+B+cf; carry_out = carry.
  - 0101 SBB: A-B-cf; carry_out = borrow.
  - 0011 and 0111 NEG: ~B+1; carry_out = 0.
  - 1000 AND, 1001 XOR, 1010 OR: carry_out = 0.
  - 1011 NOT: ~B; carry_out = 0.
  - 1100 SHR: A>>1, zero fill; carry_out = A[0].
  - 1101 SHL: A<<1; carry_out = A[WIDTH-1].
  - 1110 ROR: {A[0],A[WIDTH-1:1]}; carry_out = A[0].
  - 1111 ROL: {A[WIDTH-2:0],A[WIDTH-1]}; carry_out = A[WIDTH-1].
  - 0010, 0110: result 0, carry_out = 0, cf unchanged.
- Compare flags: computed on every op and travel with it. Exactly one of equal/greater/smaller is 1 for a valid output; all are 0 when out_valid=0.
- zero: computed from the final result.
- Wrap-around: ADD 0xFF+0x01 gives 0x00 with carry 1. SUB 0x00-0x01 gives 0xFF with borrow 1.

Test Plan:
- Basic add: WIDTH=8, LATENCY=8, out_ready=1, A=0x14 B=0x04 sel=0000 at edge k -> out_valid after edge k+7, alu_out=0x18, carry 0, greater=1, zero 0.
- Opcode sweep: sweep sel 0000..1111 on consecutive cycles with A=0x14 B=0x04 -> 16 consecutive valid outputs matching the map, including 0x10 SUB, 0xFC NEG, 0x0A SHR, 0x28 SHL, 0x0A ROR, 0x28 ROL; 0010/0110 give 0x00 with zero=1.
- Carry chain: ADD 0xFF+0x01, then ADC 0x00+0x00, then SUB 0x00-0x01, then SBB 0x05-0x01 -> results 0x00/c1, 0x01/c0, 0xFF/b1, 0x03/b0.
- Backpressure: hold out_ready=0 for 5 cycles while streaming -> in_ready=0 after the first output appears, output stable, no loss or duplication; all results in order after release.
- Compare modes: A=0x0A B=0xF6 -> SIGNED_CMP=0: smaller=1; SIGNED_CMP=1: greater=1. ADD result 0x00, carry 1, zero=1.
- Reset mid-stream: assert rst with 4 ops in flight -> all outputs 0 next cycle, none of those ops emerge later. First op after reset sees cf=0 (ADC 0x01+0x01 = 0x02).
